// File: rtl/movavg_frame_unpacker_pkg.sv
//==============================================================================
// Module   : movavg_frame_unpacker_pkg
// Brief    : Moving-average frame types, geometry and lv<->struct helpers.
// Revision : 1.0
//==============================================================================
`default_nettype none

package movavg_frame_unpacker_pkg;

    localparam int WINDOW      = 16;
    localparam int WIDTH       = 8;
    localparam int FRAME_BYTES = WINDOW + 2;
    localparam int FRAME_BITS  = FRAME_BYTES * WIDTH;

    typedef logic signed [WIDTH-1:0] sample_t;
    // Ascending range puts element 0 in the MSBs of the packed vector.
    typedef sample_t [0:WINDOW-1] window_t;

    typedef struct packed {
        window_t window;
        sample_t sel1;
        sample_t result;
    } frame_t;

    typedef logic [FRAME_BITS-1:0] frame_lv_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_HOLD = 2'd2
    } unpack_state_t;

    function automatic frame_lv_t pack_frame(input frame_t f);
        return frame_lv_t'(f);
    endfunction

    function automatic frame_t unpack_frame(input frame_lv_t lv);
        return frame_t'(lv);
    endfunction

endpackage

`default_nettype wire

// File: rtl/movavg_frame_unpacker.sv
//==============================================================================
// Module   : movavg_frame_unpacker
// Brief    : Byte-serial decoder rebuilding a moving-average state frame.
// Revision : 1.0
//==============================================================================
`default_nettype none

module movavg_frame_unpacker #(
    parameter int WINDOW = 16,
    parameter int WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    input  logic                      in_sop,
    output logic                      in_ready,
    output logic [WINDOW*WIDTH-1:0]   out_window,
    output logic [WIDTH-1:0]          out_sel1,
    output logic [WIDTH-1:0]          out_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      err,
    output logic [15:0]               frame_cnt
);

    import movavg_frame_unpacker_pkg::*;

    localparam int N_BYTES = WINDOW + 2;
    localparam int IDX_W   = $clog2(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    unpack_state_t             state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      err_q, err_d;
    logic                      out_valid_q;
    frame_t                    out_q;
    logic [15:0]               frame_cnt_q;
    logic [WIDTH-1:0]          buf_q [N_BYTES];
    logic [WIDTH-1:0]          w_buf_d [N_BYTES];
    logic [N_BYTES*WIDTH-1:0]  w_asm_lv;

    logic                      w_acc;
    logic                      w_slot_free;
    logic                      w_out_hs;
    logic                      w_wr;
    logic [IDX_W-1:0]          w_wr_idx;
    logic                      w_load;

    assign in_ready    = (state_q != S_HOLD);
    assign w_acc       = in_valid && in_ready;
    assign w_out_hs    = out_valid_q && out_ready;
    assign w_slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = 1'b0;
        w_wr     = 1'b0;
        w_wr_idx = idx_q;
        w_load   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_acc) begin
                    if (in_sop) begin
                        w_wr     = 1'b1;
                        w_wr_idx = '0;
                        idx_d    = IDX_W'(1);
                        state_d  = S_RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (w_acc) begin
                    w_wr = 1'b1;
                    if (in_sop) begin
                        // Restart on the new frame; the partial one is lost.
                        err_d    = 1'b1;
                        w_wr_idx = '0;
                        idx_d    = IDX_W'(1);
                    end else if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (w_slot_free) begin
                            w_load  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (w_slot_free) begin
                    w_load  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Buffer view with the current byte merged in, so the last byte can be
    // forwarded to the output in the same cycle it is accepted.
    always_comb begin
        w_buf_d = buf_q;
        if (w_wr) begin
            w_buf_d[w_wr_idx] = in_data;
        end
    end

    always_comb begin
        w_asm_lv = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            w_asm_lv[(N_BYTES-1-i)*WIDTH +: WIDTH] = w_buf_d[i];
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= w_buf_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            if (w_load) begin
                out_q       <= unpack_frame(w_asm_lv);
                out_valid_q <= 1'b1;
            end else if (w_out_hs) begin
                out_valid_q <= 1'b0;
            end
            if (w_out_hs) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign out_window = out_q.window;
    assign out_sel1   = out_q.sel1;
    assign out_result = out_q.result;
    assign out_valid  = out_valid_q;
    assign err        = err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_movavg_frame_unpacker.sv
//==============================================================================
// Module   : tb_movavg_frame_unpacker
// Brief    : Self-checking bench for movavg_frame_unpacker against a frame model.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_movavg_frame_unpacker;

    localparam int WINDOW      = 16;
    localparam int WIDTH       = 8;
    localparam int FRAME_BYTES = WINDOW + 2;
    localparam int FB          = FRAME_BYTES * WIDTH;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [WIDTH-1:0]        in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_sop = 1'b0;
    logic                    in_ready;
    logic [WINDOW*WIDTH-1:0] out_window;
    logic [WIDTH-1:0]        out_sel1;
    logic [WIDTH-1:0]        out_result;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic                    err;
    logic [15:0]             frame_cnt;

    movavg_frame_unpacker #(.WINDOW(WINDOW), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_ready   (in_ready),
        .out_window (out_window),
        .out_sel1   (out_sel1),
        .out_result (out_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [FB-1:0] exp_q [$];      // frames completed but not yet handshaken
    logic [7:0]    partial [$];    // bytes of the frame under assembly
    logic [15:0]   exp_cnt = '0;
    bit            exp_err_pend = 1'b0;
    bit            last_acc = 1'b0;
    bit            rand_ready = 1'b0;

    task automatic check(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Frame-level model: sees the byte stream and output handshakes only.
    task automatic monitor();
        int            sz;
        bit            acc;
        logic [FB-1:0] f;
        sz = exp_q.size();
        check("in_ready",  FB'(in_ready),  FB'(sz < 2));
        check("out_valid", FB'(out_valid), FB'(sz > 0));
        check("err",       FB'(err),       FB'(exp_err_pend));
        check("frame_cnt", FB'(frame_cnt), FB'(exp_cnt));
        if (sz > 0) check("out_frame", {out_window, out_sel1, out_result}, exp_q[0]);
        if (sz > 0 && out_ready) begin
            void'(exp_q.pop_front());
            exp_cnt++;
        end
        exp_err_pend = 1'b0;
        acc      = in_valid && (sz < 2);
        last_acc = acc;
        if (acc) begin
            if (in_sop) begin
                if (partial.size() > 0) exp_err_pend = 1'b1;
                partial.delete();
                partial.push_back(in_data);
            end else if (partial.size() == 0) begin
                exp_err_pend = 1'b1;
            end else begin
                partial.push_back(in_data);
                if (partial.size() == FRAME_BYTES) begin
                    f = '0;
                    foreach (partial[i]) f = {f[FB-WIDTH-1:0], partial[i]};
                    exp_q.push_back(f);
                    partial.delete();
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic send_byte(input logic [7:0] d, input bit sop);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        guard    = 0;
        do begin
            cycle();
            guard++;
        end while (!last_acc && guard < 200);
        if (!last_acc) check("accept_timeout", FB'(last_acc), FB'(1));
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b [FRAME_BYTES]);
        for (int i = 0; i < FRAME_BYTES; i++) send_byte(b[i], i == 0);
    endtask

    task automatic rand_frame(output logic [7:0] b [FRAME_BYTES]);
        for (int i = 0; i < FRAME_BYTES; i++) b[i] = 8'($urandom);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        partial.delete();
        exp_err_pend = 1'b0;
        exp_cnt      = '0;
    endtask

    logic [7:0]   fa [FRAME_BYTES];
    logic [7:0]   fb [FRAME_BYTES];
    logic [127:0] c_win;
    logic [15:0]  cnt0;

    initial begin
        // Reset state
        do_reset();
        idle(2);
        check("rst_window", FB'(out_window), FB'(0));
        check("rst_sel1",   FB'(out_sel1),   FB'(0));
        check("rst_result", FB'(out_result), FB'(0));

        // Nominal frame
        out_ready = 1'b1;
        for (int i = 0; i < WINDOW; i++) fa[i] = 8'(i + 1);
        fa[WINDOW]   = 8'h7F;
        fa[WINDOW+1] = 8'h80;
        c_win = 128'h0102030405060708090A0B0C0D0E0F10;
        send_frame(fa);
        check("nom_valid",  FB'(out_valid),  FB'(1));
        check("nom_window", FB'(out_window), FB'(c_win));
        check("nom_sel1",   FB'(out_sel1),   FB'(8'h7F));
        check("nom_result", FB'($signed(out_result) == -128), FB'(1));
        cycle();
        check("nom_cnt", FB'(frame_cnt), FB'(16'd1));
        idle(2);

        // Backpressure: second frame parks in HOLD behind the first
        out_ready = 1'b0;
        rand_frame(fa);
        rand_frame(fb);
        send_frame(fa);
        send_frame(fb);
        idle(4);
        check("bp_ready", FB'(in_ready), FB'(0));
        check("bp_hold",  FB'(out_sel1), FB'(fa[WINDOW]));
        out_ready = 1'b1;
        cycle();
        check("bp_second", FB'(out_result), FB'(fb[WINDOW+1]));
        check("bp_ready1", FB'(in_ready), FB'(1));
        idle(3);

        // Stray byte in IDLE
        send_byte(8'h55, 1'b0);
        check("stray_err", FB'(err), FB'(1));
        cycle();
        check("stray_err_clr", FB'(err), FB'(0));
        rand_frame(fa);
        send_frame(fa);
        idle(3);

        // Early sop at byte 7
        rand_frame(fb);
        for (int i = 0; i < 7; i++) send_byte(fb[i], i == 0);
        rand_frame(fa);
        send_frame(fa);
        idle(3);

        // Reset mid-frame
        rand_frame(fb);
        for (int i = 0; i < 9; i++) send_byte(fb[i], i == 0);
        do_reset();
        idle(1);
        check("rmid_valid", FB'(out_valid), FB'(0));
        check("rmid_cnt",   FB'(frame_cnt), FB'(0));
        check("rmid_ready", FB'(in_ready),  FB'(1));
        rand_frame(fa);
        send_frame(fa);
        idle(3);

        // Reset while a frame is held and another is presented
        out_ready = 1'b0;
        rand_frame(fa);
        rand_frame(fb);
        send_frame(fa);
        send_frame(fb);
        do_reset();
        idle(1);
        check("rhold_valid", FB'(out_valid), FB'(0));
        check("rhold_ready", FB'(in_ready),  FB'(1));
        out_ready = 1'b1;

        // Back-to-back frames
        cnt0 = frame_cnt;
        for (int n = 0; n < 3; n++) begin
            rand_frame(fa);
            send_frame(fa);
        end
        idle(2);
        check("b2b_cnt", FB'(frame_cnt - cnt0), FB'(3));

        // Randomised traffic with gaps, stray bytes, truncated frames
        rand_ready = 1'b1;
        for (int n = 0; n < 25; n++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 7);
            rand_frame(fa);
            if (kind == 0) begin
                send_byte(8'($urandom), 1'b0);
            end else begin
                len = (kind == 1) ? $urandom_range(1, FRAME_BYTES - 1) : FRAME_BYTES;
                for (int i = 0; i < len; i++) begin
                    send_byte(fa[i], i == 0);
                    idle($urandom_range(0, 1));
                end
            end
            idle($urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/movavg_frame_unpacker.md
Name: movavg_frame_unpacker

Overview:
- Byte-serial decoder for the packed moving-average state word. It is the reverse of the package's struct-to-logic-vector packing.
- Receives a (WINDOW+2)-byte frame over a valid/ready stream and rebuilds the 16-sample window, the product1 scalar (sel1) and the product0 scalar (result).
- Presents the rebuilt frame as one output beat. Used to restore or inject filter state from a host/debug link.

Parameters:
- WINDOW, 16, number of window samples per frame.
- WIDTH, 8, bits per sample, and bits per stream byte.
- FRAME_BYTES, WINDOW+2, derived (localparam), bytes per frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  frame byte
- in_valid  in  1  in_data is valid
- in_sop  in  1  marks the first byte of a frame; qualified by in_valid
- in_ready  out  1  block accepts a byte this cycle
- out_window  out  WINDOW*WIDTH  packed window; element 0 in the MSBs (same layout as the package packing)
- out_sel1  out  WIDTH  product1 sel1 scalar, signed
- out_result  out  WIDTH  product0 sel1 scalar, signed
- out_valid  out  1  output frame valid
- out_ready  in  1  downstream accepts the output frame
- err  out  1  one-cycle pulse on a framing error
- frame_cnt  out  16  count of frames delivered; wraps at 2^16

Behaviour:
- Byte accepted when in_valid && in_ready.
- Byte order is MSB-first to match the packed vector:
  - bytes 0..WINDOW-1 -> window[0..WINDOW-1]
  - byte WINDOW -> sel1
  - byte WINDOW+1 -> result
- States:
  - IDLE: in_ready=1. Accepted byte with in_sop=1 -> store as byte 0, idx=1, go to RECV. Accepted byte with in_sop=0 -> byte dropped, err pulse, stay IDLE.
  - RECV: in_ready=1. Accepted byte with in_sop=0 -> store at idx, idx++.
    - On the last byte (idx=FRAME_BYTES-1), if the output slot is free (!out_valid || out_ready): copy the assembly buffer, including the last byte, into the output registers; out_valid=1 next cycle; go to IDLE.
    - Otherwise go to HOLD.
  - RECV with in_sop=1 on an accepted byte: abandon the partial frame, err pulse, store the byte as byte 0, idx=1, stay RECV.
  - HOLD: in_ready=0. When the output slot frees (!out_valid || out_ready), transfer the assembly buffer to the output; out_valid=1 next cycle; go to IDLE.
- Latency: out_valid rises the cycle after the last byte is accepted when the slot is free. Max throughput is one frame per FRAME_BYTES cycles with no bubbles.
- Output registers hold stable while out_valid && !out_ready. out_valid clears on handshake unless a new transfer occurs in the same cycle; the new frame then replaces the old with out_valid staying 1.
- frame_cnt increments on each output handshake (out_valid && out_ready).
- No arithmetic on the data: bytes are copied bit-exact and signedness is interpretation only.
- Reset values: state=IDLE, idx=0, out_valid=0, err=0, frame_cnt=0, out_window/out_sel1/out_result=0, in_ready=1 from the first cycle after reset.
- Reset mid-frame or in HOLD discards the partial or held frame, including any unacknowledged output frame.
- Simultaneous events: the last byte and an output handshake in the same cycle is legal and yields back-to-back out_valid.

Decomposition:
- Shared package (alongside the existing moving-average types):
  - FRAME_BYTES constant.
  - Typedef for the WINDOW-sample signed array.
  - A frame struct {window, sel1, result}.
  - The lv-to-struct unpack function (inverse of the existing packing functions).
- No sub-module: a single FSM, index counter and two register banks.

Test Plan:
- Nominal frame: sop + bytes 0x01..0x10, 0x7F, 0x80 with out_ready=1. Required: out_valid one cycle after the last byte; out_window = 0x0102...10, out_sel1=0x7F, out_result=0x80 (-128); frame_cnt=1.
- Backpressure: out_ready=0 while a second frame completes. Required: second frame enters HOLD with in_ready=0 and the first frame held stable. Raise out_ready -> first frame handshakes, second frame is presented, then in_ready=1.
- Stray byte: in IDLE send 0x55 with in_sop=0. Required: err pulses once; no state change; the next valid frame decodes correctly.
- Early sop: sop at byte 7 of a frame. Required: err pulse; the new frame decodes fully; the old partial frame is never output.
- Reset mid-frame: rst after 9 bytes. Required: out_valid=0, frame_cnt=0, in_ready=1; a fresh frame decodes.
- Back-to-back: 3 frames streamed continuously with out_ready=1. Required: 3 out_valid beats spaced 18 cycles apart; frame_cnt=3.
